// File: rtl/hermes_switch_control_pkg.sv
// Shared types and constants for the Hermes switch allocator: port numbering
// and XY address field helpers.
package hermes_switch_control_pkg;

    localparam int NPORT = 5;

    typedef logic [2:0] port_t;

    localparam port_t EAST  = 3'd0;
    localparam port_t WEST  = 3'd1;
    localparam port_t NORTH = 3'd2;
    localparam port_t SOUTH = 3'd3;
    localparam port_t LOCAL = 3'd4;

    function automatic logic [7:0] x_of(input logic [15:0] addr);
        return addr[15:8];
    endfunction

    function automatic logic [7:0] y_of(input logic [15:0] addr);
        return addr[7:0];
    endfunction

endpackage

// File: rtl/hermes_switch_control_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo N, with ptr_i itself considered last.
module hermes_rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          valid_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        valid_o = 1'b0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = N; k >= 1; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                grant_o = IW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes router switch allocator: round-robin header selection, XY routing,
// output allocation and release when the granted packet's tail has left.
module hermes_switch_control
    import hermes_switch_control_pkg::*;
#(
    parameter logic [15:0] ADDRESS   = 16'h0000,
    parameter int          FLIT_SIZE = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NPORT-1:0]                    req_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]     header_i,
    input  logic [NPORT-1:0]                    sending_i,
    output logic [NPORT-1:0]                    ack_o,
    output port_t [NPORT-1:0]                   sel_o,
    output logic [NPORT-1:0]                    out_busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ROUTE = 2'd2;
    localparam logic [1:0] S_GRANT = 2'd3;

    localparam logic [7:0] LX = x_of(ADDRESS);
    localparam logic [7:0] LY = y_of(ADDRESS);

    logic [1:0]              state_q, state_d;
    port_t                   rr_ptr_q, rr_ptr_d;
    port_t                   cur_q, cur_d;
    port_t                   dir_q, dir_d;
    logic [7:0]              tx_q, tx_d;
    logic [7:0]              ty_q, ty_d;
    logic [NPORT-1:0]        out_busy_q, out_busy_d;
    port_t [NPORT-1:0]       sel_q, sel_d;
    logic [NPORT-1:0]        in_busy_q, in_busy_d;
    logic [NPORT-1:0]        sending_q;

    logic [NPORT-1:0]        eligible;
    logic [NPORT-1:0]        tail_done;
    logic [NPORT-1:0]        out_release;
    logic [NPORT-1:0]        unused_hdr_bits;
    port_t                   arb_idx;
    logic                    arb_valid;
    logic [15:0]             arb_hdr;
    port_t                   route_dir;

    assign eligible  = req_i & ~in_busy_q;
    assign tail_done = sending_q & ~sending_i & in_busy_q;
    assign arb_hdr   = header_i[arb_idx][15:0];

    // An output frees up when the input it is connected to finishes its packet.
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
        assign out_release[gi]     = out_busy_q[gi] & tail_done[sel_q[gi]];
        assign unused_hdr_bits[gi] = ^header_i[gi][FLIT_SIZE-1:16];
    end

    hermes_rr_arbiter #(
        .N  (NPORT),
        .IW ($bits(port_t))
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        route_dir = LOCAL;
        if (tx_q > LX) begin
            route_dir = EAST;
        end else if (tx_q < LX) begin
            route_dir = WEST;
        end else if (ty_q > LY) begin
            route_dir = NORTH;
        end else if (ty_q < LY) begin
            route_dir = SOUTH;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_d      = cur_q;
        dir_d      = dir_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        sel_d      = sel_q;
        out_busy_d = out_busy_q & ~out_release;
        in_busy_d  = in_busy_q & ~tail_done;

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_valid) begin
                    cur_d   = arb_idx;
                    tx_d    = x_of(arb_hdr);
                    ty_d    = y_of(arb_hdr);
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                // Busy check uses the pre-release value: a same-cycle release retries.
                dir_d    = route_dir;
                rr_ptr_d = cur_q;
                state_d  = out_busy_q[route_dir] ? S_IDLE : S_GRANT;
            end
            default: begin
                out_busy_d[dir_q] = 1'b1;
                sel_d[dir_q]      = cur_q;
                in_busy_d[cur_q]  = 1'b1;
                state_d           = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= LOCAL;
            cur_q      <= EAST;
            dir_q      <= EAST;
            tx_q       <= '0;
            ty_q       <= '0;
            out_busy_q <= '0;
            sel_q      <= '0;
            in_busy_q  <= '0;
            sending_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            out_busy_q <= out_busy_d;
            sel_q      <= sel_d;
            in_busy_q  <= in_busy_d;
            sending_q  <= sending_i;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == S_GRANT) begin
            ack_o[cur_q] = 1'b1;
        end
    end

    assign sel_o      = sel_q;
    assign out_busy_o = out_busy_q;

endmodule
